// File: rtl/div_unit_pkg.sv
// Shared encodings for the multi-cycle divider: FSM states and handshake levels.
// The state values match the DIV_* encodings used by the rest of the pipeline.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU; result = {remainder, quotient} for HI/LO.
// Handshake: EX holds start high until it samples ready=1, then drops start; annul aborts at any time.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   div_num1,
    input  logic [WIDTH-1:0]   div_num2,
    input  logic               start,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_e         state_q, state_d;
    logic [WIDTH-1:0]   quot_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sign_q_q;
    logic               sign_r_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;

    logic               accept;
    logic               keep_result;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               fits;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign accept      = (state_q == DIV_IDLE) && (start == DIV_START) && !annul;
    assign keep_result = !annul && (start == DIV_START);

    // Signed operands are divided as magnitudes; signs are reapplied in END.
    assign mag1 = (signed_div && div_num1[WIDTH-1]) ? -div_num1 : div_num1;
    assign mag2 = (signed_div && div_num2[WIDTH-1]) ? -div_num2 : div_num2;

    // The shifted remainder needs one extra bit before the compare.
    assign shifted = {rem_q, quot_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor_q};
    assign fits    = (shifted >= {1'b0, divisor_q});

    assign quot_fix = sign_q_q ? -quot_q : quot_q;
    assign rem_fix  = sign_r_q ? -rem_q  : rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (accept) begin
                    stall   = 1'b1;
                    state_d = (div_num2 == '0) ? DIV_BYZERO : DIV_ON;
                end
            end
            DIV_BYZERO: begin
                stall   = 1'b1;
                state_d = DIV_END;
            end
            DIV_ON: begin
                stall = 1'b1;
                if (annul) begin
                    state_d = DIV_IDLE;
                end else if (cnt_q == LAST_STEP) begin
                    state_d = DIV_END;
                end
            end
            DIV_END: begin
                if (!keep_result) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            sign_q_q  <= 1'b0;
            sign_r_q  <= 1'b0;
            result_q  <= '0;
            ready_q   <= DIV_RESULT_NOT_READY;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    ready_q <= DIV_RESULT_NOT_READY;
                    if (accept && (div_num2 != '0)) begin
                        quot_q    <= mag1;
                        divisor_q <= mag2;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        sign_q_q  <= signed_div && (div_num1[WIDTH-1] ^ div_num2[WIDTH-1]);
                        sign_r_q  <= signed_div && div_num1[WIDTH-1];
                    end
                end
                DIV_BYZERO: begin
                    quot_q   <= '0;
                    rem_q    <= '0;
                    sign_q_q <= 1'b0;
                    sign_r_q <= 1'b0;
                end
                DIV_ON: begin
                    if (!annul) begin
                        if (fits) begin
                            rem_q  <= diff[WIDTH-1:0];
                            quot_q <= {quot_q[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_q  <= shifted[WIDTH-1:0];
                            quot_q <= {quot_q[WIDTH-2:0], 1'b0};
                        end
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DIV_END: begin
                    // The first END edge publishes the result; later edges rewrite the same value.
                    if (keep_result) begin
                        result_q <= {rem_fix, quot_fix};
                        ready_q  <= DIV_RESULT_READY;
                    end else begin
                        ready_q  <= DIV_RESULT_NOT_READY;
                    end
                end
                default: ready_q <= DIV_RESULT_NOT_READY;
            endcase
        end
    end

    assign result = result_q;
    assign ready  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed MIPS cases plus randomized divisions
// compared against an arithmetic model of DIV/DIVU.
module tb_div_unit;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          signed_div;
    logic [W-1:0]  div_num1;
    logic [W-1:0]  div_num2;
    logic          start;
    logic          annul;
    logic [2*W-1:0] result;
    logic          ready;
    logic          stall;

    int checks = 0;
    int passes = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] cur_exp;
    logic           ready_prev;

    div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .div_num1   (div_num1),
        .div_num2   (div_num2),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stall      (stall)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: MIPS DIV truncates toward zero, remainder takes the dividend's sign.
    function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        if (b == 0) return '0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[W-1:0], q[W-1:0]};
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[W-1:0], uq[W-1:0]};
    endfunction

    // scoreboard: every ready window must carry the next expected result, held stable
    always @(negedge clk) begin
        if (rst) begin
            ready_prev = 1'b0;
        end else begin
            if (ready) begin
                if (!ready_prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_ready: got ready=1 expected no pending result");
                        cur_exp = 'x;
                    end else begin
                        cur_exp = exp_q.pop_front();
                    end
                end
                chk("result", result, cur_exp);
            end
            ready_prev = ready;
        end
    end

    // Drive one division; checks latency, stall profile, then holds start before releasing.
    task automatic run_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] exp, input int hold);
        int k;
        int lat;
        bit got;
        bit stall_bad;
        lat = (b == 0) ? 2 : 33;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        signed_div = s; div_num1 = a; div_num2 = b; start = 1'b1;
        @(negedge clk);
        chk("stall_idle_start", {63'd0, stall}, 64'd1);
        k = 0; got = 0; stall_bad = 0;
        while (k < 100 && !got) begin
            @(posedge clk); #1;
            div_num1 = $urandom; div_num2 = $urandom; signed_div = $urandom_range(0, 1);
            @(negedge clk);
            if (ready) begin
                got = 1;
            end else begin
                if (stall !== (k < lat - 1)) stall_bad = 1;
                k++;
            end
        end
        if (!got) begin
            checks++;
            $display("FAIL ready_timeout: got no ready expected ready after %0d edges", lat);
            return;
        end
        chk("latency", 64'(k), 64'(lat));
        chk("stall_profile", {63'd0, stall_bad}, 64'd0);
        chk("stall_ready", {63'd0, stall}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("ready_hold", {63'd0, ready}, 64'd1);
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_drop", {62'd0, ready, stall}, 64'd0);
    endtask

    task automatic abort_at(input logic [W-1:0] a, input logic [W-1:0] b, input int iter, input bit use_rst);
        @(posedge clk); #1;
        signed_div = 1'b0; div_num1 = a; div_num2 = b; start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < iter; i++) @(posedge clk);
        #1;
        start = 1'b0;
        if (use_rst) rst = 1'b1; else annul = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; annul = 1'b0;
        @(negedge clk);
        if (use_rst) chk("rst_mid_op", {result[62:0], ready} ^ {64'd0} | {63'd0, stall}, 64'd0);
        else         chk("annul_idle", {62'd0, ready, stall}, 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready !== 1'b0) begin
                chk("no_ready_after_abort", {63'd0, ready}, 64'd0);
                break;
            end
        end
    endtask

    initial begin
        logic s;
        logic [W-1:0] a, b;
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; div_num1 = '0; div_num2 = '0;
        ready_prev = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", result, 64'd0);
        chk("reset_ready_stall", {62'd0, ready, stall}, 64'd0);
        #1 rst = 1'b0;

        // pin the model against hand-computed values
        chk("model_100_7",  model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        chk("model_m7_2",   model(1'b1, 32'hFFFFFFF9, 32'd2), {32'hFFFFFFFF, 32'hFFFFFFFD});
        chk("model_corner", model(1'b1, 32'h80000000, 32'hFFFFFFFF), {32'h0, 32'h80000000});

        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 0);
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0);
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 0);
        run_div(1'b0, 32'h12345678, 32'd0, 64'h0, 0);
        run_div(1'b0, 32'd1000, 32'd9, {32'd1, 32'd111}, 5);
        run_div(1'b1, 32'd81, 32'd9, {32'd0, 32'd9}, 0);

        abort_at(32'hDEADBEEF, 32'd3, 10, 1'b0);
        run_div(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 0);

        abort_at(32'hCAFEF00D, 32'd17, 20, 1'b1);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 1);
        run_div(1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 0);

        for (int n = 0; n < 25; n++) begin
            s = $urandom_range(0, 1);
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(0, 15);
                1:       b = 32'hFFFFFFFF - $urandom_range(0, 3);
                default: b = $urandom;
            endcase
            run_div(s, a, b, model(s, a, b), $urandom_range(0, 3));
        end

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
- Sits beside the combinational ALU and feeds the HI/LO register write path: HI receives the remainder, LO receives the quotient.
- Raises a stall request so the hazard unit freezes the front of the pipeline while a division is in flight.
- Supports annulment when the instruction is flushed by an exception, ERET or a branch.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled only when start is accepted.
- div_num1  input  WIDTH  dividend (rs); sampled only when start is accepted.
- div_num2  input  WIDTH  divisor (rt); sampled only when start is accepted.
- start  input  1  level request, held high by EX until ready is seen.
- annul  input  1  abort the current division.
- result  output  2*WIDTH  {remainder, quotient}.
- ready  output  1  result valid.
- stall  output  1  hold the pipeline.

Behaviour:
- Reset: state=IDLE; result=0, ready=0, counter=0, internal dividend/divisor registers=0.
- States: IDLE, DIVZERO, ON, END (encodings in defines.vh).
- IDLE:
  - start=1 and annul=0 and div_num2==0: go to DIVZERO.
  - start=1 and annul=0 and div_num2!=0: go to ON and latch operands.
    - For signed_div=1, latch the magnitudes of the operands.
    - Also latch sign_q = num1[31]^num2[31] and sign_r = num1[31].
    - Clear the counter and the partial remainder.
  - Otherwise stay in IDLE.
- DIVZERO: next edge go to END with the raw quotient and remainder forced to 0.
- ON:
  - annul=1: go to IDLE immediately; the partial result is discarded and ready stays 0.
  - Otherwise each edge performs one restoring step:
    - Shift {rem,quot} left by 1.
    - If the shifted remainder is ≥ the divisor (unsigned), subtract the divisor and set the quotient LSB.
    - Increment the counter.
  - The step made with counter==WIDTH-1 is the last; that edge goes to END.
- END:
  - On entry, register the result and set ready=1.
  - Signed results are corrected: quotient negated if sign_q, remainder negated if sign_r.
  - Stay in END while start=1; ready and result stay stable.
  - When start=0: go to IDLE with ready=0; result keeps its value (don't-care).
  - annul=1 in END: go to IDLE with ready=0.
- Latency, counted from edge E0 (start sampled in IDLE):
  - Normal case: WIDTH iterations on E1..E32, ready=1 visible after E33, so ready is first high 33 cycles after E0.
  - Divide by zero: ready visible after E2.
- stall (combinational):
  - 1 when (IDLE and start and !annul), or state ∈ {DIVZERO, ON}.
  - 0 in END, so EX advances in the same cycle ready=1.
- Signed corner case: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. Result is 2's-complement wrap; no trap.
- Divide by zero: result 0, no exception; MIPS leaves the value unpredictable, and this block fixes it at 0.
- Operands are never re-sampled during ON or END; changes on div_num1/div_num2 are ignored.
- rst has priority over annul and start in every state; rst mid-operation returns to the reset values on that edge.
- start and annul both high in IDLE: the request is not accepted and the state stays IDLE.

Decomposition:
- defines.vh gains:
  - State encodings: `DIV_IDLE, `DIV_BYZERO, `DIV_ON, `DIV_END (2 bits).
  - `DIV_RESULT_READY / `DIV_RESULT_NOT_READY.
  - `DIV_START / `DIV_STOP.
- No sub-module. The one-step subtract/compare stays inline; a separate div_step module is not warranted at this size.

Test Plan:
- Unsigned 100 / 7 (signed_div=0):
  - result={32'd2, 32'd14}.
  - ready rises exactly 33 cycles after the start edge.
  - stall=1 during those cycles and 0 in the ready cycle.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002): result={0xFFFFFFFF, 0xFFFFFFFD}. Also check 7 / −2 gives {0x00000001, 0xFFFFFFFD}.
- Divide by zero, 0x12345678 / 0:
  - ready after 2 edges, result=64'h0.
  - stall high only for IDLE-with-start and DIVZERO.
- Start holding and release:
  - Hold start high 5 cycles after ready: result stable, ready=1.
  - Drop start: next cycle ready=0, state IDLE.
  - New start is accepted on the following edge.
- Annul at iteration 10:
  - Back to IDLE next edge, ready never rises, stall=0.
  - A fresh 50 / 5 then gives {0, 10}.
- Reset and signed corner case:
  - rst asserted at iteration 20 gives all outputs 0 next edge.
  - Then signed 0x80000000 / 0xFFFFFFFF gives {0x00000000, 0x80000000}.
  - Unsigned 0xFFFFFFFF / 1 gives {0, 0xFFFFFFFF}.
